// File: rtl/vga_sync_receiver.sv
// Pixel-clock receiver for an active-low hsync/vsync raster: measures line length,
// locks to the raster and emits (x, y, rgb) with pixel_valid two cycles after the port sample.
module vga_sync_receiver #(
  parameter logic [9:0] HTOTAL     = 10'd801,
  parameter logic [9:0] HOFFSET    = 10'd144,
  parameter logic [9:0] VOFFSET    = 10'd34,
  parameter logic [9:0] WIDTH      = 10'd640,
  parameter logic [9:0] HEIGHT     = 10'd480,
  parameter logic [3:0] LOCK_LINES = 4'd4
) (
  input  logic        vgaclk,
  input  logic        reset_b,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [23:0] rgb,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        line_err,
  output logic [7:0]  err_count
);

  localparam logic [1:0]  SEARCH  = 2'd0;
  localparam logic [1:0]  ACQUIRE = 2'd1;
  localparam logic [1:0]  LOCKED  = 2'd2;
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [10:0] H_END   = {1'b0, HOFFSET} + {1'b0, WIDTH};
  localparam logic [10:0] V_END   = {1'b0, VOFFSET} + {1'b0, HEIGHT};

  logic        r_hs, r_hs_d, r_vs, r_vs_d;
  logic [23:0] r_rgb_s1, r_rgb_s2;
  logic [9:0]  r_h, r_v;
  logic        r_vpend;
  logic [1:0]  r_state;
  logic [3:0]  r_good;
  logic        r_miss;
  logic [7:0]  r_err;
  logic        r_fs_p, r_lerr_p;

  logic        w_hfall, w_vfall, w_origin, w_len_ok;
  logic [10:0] w_len;
  logic [9:0]  w_h_next, w_v_next;
  logic        w_vpend_next;
  logic [1:0]  w_state_next;
  logic [3:0]  w_good_next;
  logic        w_miss_next;
  logic [7:0]  w_err_next;
  logic        w_fs, w_lerr;
  logic        w_pix_valid;

  // Input register stage; sync history resets to the deasserted level
  always_ff @(posedge vgaclk) begin
    if (!reset_b) begin
      r_hs     <= 1'b1;
      r_hs_d   <= 1'b1;
      r_vs     <= 1'b1;
      r_vs_d   <= 1'b1;
      r_rgb_s1 <= 24'd0;
    end else begin
      r_hs     <= hsync;
      r_hs_d   <= r_hs;
      r_vs     <= vsync;
      r_vs_d   <= r_vs;
      r_rgb_s1 <= {r_in, g_in, b_in};
    end
  end

  // Edge detection and raster counters; a vsync fall is held until the next hsync fall
  always_comb begin
    w_hfall  = r_hs_d & ~r_hs;
    w_vfall  = r_vs_d & ~r_vs;
    w_origin = w_hfall & (r_vpend | w_vfall);
    w_len    = {1'b0, r_h} + 11'd1;
    w_len_ok = (w_len == {1'b0, HTOTAL});
    if (w_hfall) begin
      w_h_next = 10'd0;
    end else if (r_h == CNT_MAX) begin
      w_h_next = CNT_MAX;
    end else begin
      w_h_next = r_h + 10'd1;
    end
    if (w_origin) begin
      w_v_next     = 10'd0;
      w_vpend_next = 1'b0;
    end else if (w_hfall) begin
      w_v_next     = (r_v == CNT_MAX) ? CNT_MAX : r_v + 10'd1;
      w_vpend_next = r_vpend;
    end else begin
      w_v_next     = r_v;
      w_vpend_next = r_vpend | w_vfall;
    end
  end

  // Lock state machine; good includes the line measured at the current fall
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    w_miss_next  = r_miss;
    w_err_next   = r_err;
    w_lerr       = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_hfall) begin
          w_state_next = ACQUIRE;
          w_good_next  = 4'd0;
        end else begin
          w_state_next = SEARCH;
        end
      end
      ACQUIRE: begin
        if (w_hfall) begin
          if (!w_len_ok) begin
            w_good_next = 4'd0;
          end else if (r_good == 4'd15) begin
            w_good_next = 4'd15;
          end else begin
            w_good_next = r_good + 4'd1;
          end
          if (w_origin && (w_good_next >= LOCK_LINES)) begin
            w_state_next = LOCKED;
            w_miss_next  = 1'b0;
          end else begin
            w_state_next = ACQUIRE;
          end
        end else begin
          w_state_next = ACQUIRE;
        end
      end
      LOCKED: begin
        if (w_hfall) begin
          if (w_len_ok) begin
            w_miss_next  = 1'b0;
            w_state_next = LOCKED;
          end else begin
            w_lerr       = 1'b1;
            w_err_next   = (r_err == 8'd255) ? 8'd255 : r_err + 8'd1;
            w_miss_next  = 1'b1;
            w_state_next = r_miss ? SEARCH : LOCKED;
          end
        end else if (w_h_next == CNT_MAX) begin
          w_state_next = SEARCH;
        end else begin
          w_state_next = LOCKED;
        end
      end
      default: begin
        w_state_next = SEARCH;
      end
    endcase
    w_fs = w_origin & (w_state_next == LOCKED);
  end

  // Core state registers, aligned with the pixel carried in r_rgb_s2
  always_ff @(posedge vgaclk) begin
    if (!reset_b) begin
      r_h      <= 10'd0;
      r_v      <= 10'd0;
      r_vpend  <= 1'b0;
      r_state  <= SEARCH;
      r_good   <= 4'd0;
      r_miss   <= 1'b0;
      r_err    <= 8'd0;
      r_fs_p   <= 1'b0;
      r_lerr_p <= 1'b0;
      r_rgb_s2 <= 24'd0;
    end else begin
      r_h      <= w_h_next;
      r_v      <= w_v_next;
      r_vpend  <= w_vpend_next;
      r_state  <= w_state_next;
      r_good   <= w_good_next;
      r_miss   <= w_miss_next;
      r_err    <= w_err_next;
      r_fs_p   <= w_fs;
      r_lerr_p <= w_lerr;
      r_rgb_s2 <= r_rgb_s1;
    end
  end

  assign w_pix_valid = (r_state == LOCKED) &&
                       (r_h >= HOFFSET) && ({1'b0, r_h} < H_END) &&
                       (r_v >= VOFFSET) && ({1'b0, r_v} < V_END);

  // Registered output stage; coordinates and colour read zero outside the active area
  always_ff @(posedge vgaclk) begin
    if (!reset_b) begin
      x           <= 10'd0;
      y           <= 10'd0;
      rgb         <= 24'd0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      line_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      x           <= w_pix_valid ? (r_h - HOFFSET) : 10'd0;
      y           <= w_pix_valid ? (r_v - VOFFSET) : 10'd0;
      rgb         <= w_pix_valid ? r_rgb_s2 : 24'd0;
      pixel_valid <= w_pix_valid;
      frame_start <= r_fs_p;
      locked      <= (r_state == LOCKED);
      line_err    <= r_lerr_p;
      err_count   <= r_err;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced raster: a spec-level model predicts every
// output cycle, a queue decouples stimulus from the monitor that compares the stream.
module tb_vga_sync_receiver;

  localparam int HT  = 40;
  localparam int HO  = 8;
  localparam int VO  = 3;
  localparam int W   = 24;
  localparam int H   = 10;
  localparam int LL  = 4;
  localparam int FL  = 16;
  localparam int HSW = 4;

  localparam int S_SEARCH = 0;
  localparam int S_ACQ    = 1;
  localparam int S_LOCK   = 2;

  typedef struct packed {
    logic        pv;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic        fs;
    logic        le;
    logic        lk;
    logic [7:0]  ec;
  } exp_t;

  logic        vgaclk = 1'b0;
  logic        reset_b = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [7:0]  r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
  logic [9:0]  x, y;
  logic [23:0] rgb;
  logic        pixel_valid, frame_start, locked, line_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   fs_q[$];
  int   pix_q[$];

  // reference model state (spec terms)
  int m_h = 0, m_v = 0, m_vpend = 0, m_state = S_SEARCH, m_good = 0, m_miss = 0, m_err = 0;
  bit m_prev_hs = 1'b1, m_prev_vs = 1'b1;
  exp_t rec_d1 = '0, rec_d2 = '0;
  bit   rst_d1 = 1'b1;

  int mon_cyc = 0;
  int pix_cnt = 0;
  bit seen_fs = 1'b0;

  vga_sync_receiver #(
    .HTOTAL(10'd40), .HOFFSET(10'd8), .VOFFSET(10'd3),
    .WIDTH(10'd24), .HEIGHT(10'd10), .LOCK_LINES(4'd4)
  ) dut (
    .vgaclk(vgaclk), .reset_b(reset_b), .hsync(hsync), .vsync(vsync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .rgb(rgb), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .locked(locked), .line_err(line_err),
    .err_count(err_count)
  );

  always #5 vgaclk = ~vgaclk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  // Behavioural model of one port sample; rec is the output this sample should produce
  task automatic model_step(input bit hs, input bit vs, input bit rst,
                            input logic [23:0] pix, output exp_t rec);
    bit fall, vfall, origin;
    int len;
    rec = '0;
    if (rst) begin
      m_h = 0; m_v = 0; m_vpend = 0; m_state = S_SEARCH;
      m_good = 0; m_miss = 0; m_err = 0;
      m_prev_hs = 1'b1; m_prev_vs = 1'b1;
      return;
    end
    fall  = !hs && m_prev_hs;
    vfall = !vs && m_prev_vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    origin = 1'b0;
    len = m_h + 1;
    if (fall) begin
      m_h = 0;
      origin = (m_vpend != 0) || vfall;
      if (origin) begin
        m_v = 0;
        m_vpend = 0;
      end else begin
        m_v = (m_v < 1023) ? m_v + 1 : 1023;
      end
    end else begin
      m_h = (m_h < 1023) ? m_h + 1 : 1023;
      if (vfall) m_vpend = 1;
    end
    if (m_state == S_SEARCH) begin
      if (fall) begin
        m_state = S_ACQ;
        m_good = 0;
      end
    end else if (m_state == S_ACQ) begin
      if (fall) begin
        m_good = (len == HT) ? ((m_good < 15) ? m_good + 1 : 15) : 0;
        if (origin && m_good >= LL) begin
          m_state = S_LOCK;
          m_miss = 0;
        end
      end
    end else begin
      if (fall) begin
        if (len == HT) begin
          m_miss = 0;
        end else begin
          rec.le = 1'b1;
          m_err = (m_err < 255) ? m_err + 1 : 255;
          if (m_miss != 0) m_state = S_SEARCH;
          m_miss = 1;
        end
      end else if (m_h == 1023) begin
        m_state = S_SEARCH;
      end
    end
    rec.lk = (m_state == S_LOCK);
    rec.fs = fall && origin && (m_state == S_LOCK);
    rec.ec = 8'(m_err);
    rec.pv = rec.lk && m_h >= HO && m_h < HO + W && m_v >= VO && m_v < VO + H;
    if (rec.pv) begin
      rec.x = 10'(m_h - HO);
      rec.y = 10'(m_v - VO);
      rec.rgb = pix;
    end
  endtask

  // One clock of stimulus: drive ports, push the expected output for this edge
  task automatic drive(input bit hs, input bit vs, input bit rst);
    exp_t cur;
    exp_t e;
    @(negedge vgaclk);
    hsync   = hs;
    vsync   = vs;
    reset_b = ~rst;
    r_in    = 8'($urandom);
    g_in    = 8'($urandom);
    b_in    = 8'($urandom);
    e = (rst || rst_d1) ? exp_t'(0) : rec_d2;
    exp_q.push_back(e);
    model_step(hs, vs, rst, {r_in, g_in, b_in}, cur);
    rec_d2 = rec_d1;
    rec_d1 = cur;
    rst_d1 = rst;
  endtask

  task automatic send_frame(input int mode, input int bad_a, input int bad_b,
                            input int rst_line, input bit rnd);
    for (int l = 0; l < FL; l++) begin
      int len;
      len = HT;
      if (l == bad_a || l == bad_b) len = HT - 1;
      if (rnd && $urandom_range(0, 19) == 0) len = ($urandom_range(0, 1) == 1) ? HT + 1 : HT - 1;
      for (int c = 0; c < len; c++) begin
        bit hs, vs_low;
        hs = (c >= HSW);
        vs_low = (l < 2) || (mode == 1 && l == FL - 1 && c >= len / 2);
        drive(hs, !vs_low, (l == rst_line && c == HT / 2));
      end
    end
  endtask

  // Monitor: pop one expectation per output cycle and compare the whole output bundle
  always @(posedge vgaclk) begin
    exp_t e;
    exp_t a;
    #1;
    mon_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pv = pixel_valid; a.x = x; a.y = y; a.rgb = rgb;
      a.fs = frame_start; a.le = line_err; a.lk = locked; a.ec = err_count;
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL stream cyc=%0d got pv=%0b x=%0d y=%0d rgb=%h fs=%0b le=%0b lk=%0b ec=%0d expected pv=%0b x=%0d y=%0d rgb=%h fs=%0b le=%0b lk=%0b ec=%0d",
                   mon_cyc, a.pv, a.x, a.y, a.rgb, a.fs, a.le, a.lk, a.ec,
                   e.pv, e.x, e.y, e.rgb, e.fs, e.le, e.lk, e.ec);
      end
      if (frame_start === 1'b1) begin
        fs_q.push_back(mon_cyc);
        if (seen_fs) pix_q.push_back(pix_cnt);
        seen_fs = 1'b1;
        pix_cnt = 0;
      end
      if (pixel_valid === 1'b1) pix_cnt++;
    end
  end

  initial begin
    // reset with sync toggling
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("reset_locked", int'(locked), 0);
    check("reset_err_count", int'(err_count), 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);

    // nominal frames: lock, then frame period and pixel count
    for (int f = 0; f < 4; f++) send_frame(0, -1, -1, -1, 1'b0);
    check("fs_seen", (fs_q.size() >= 2) ? 1 : 0, 1);
    if (fs_q.size() >= 2) check("frame_period", fs_q[1] - fs_q[0], FL * HT);
    if (pix_q.size() >= 1) check("pixels_per_frame", pix_q[0], W * H);

    // single bad line
    send_frame(0, 5, -1, -1, 1'b0);
    check("single_bad_err_count", int'(err_count), 1);
    check("single_bad_locked", int'(locked), 1);

    // two consecutive bad lines
    send_frame(0, 5, 6, -1, 1'b0);
    check("double_bad_err_count", int'(err_count), 3);
    check("double_bad_locked", int'(locked), 0);

    // relock, then lose hsync
    send_frame(0, -1, -1, -1, 1'b0);
    send_frame(0, -1, -1, -1, 1'b0);
    check("relock_locked", int'(locked), 1);
    for (int i = 0; i < 1100; i++) drive(1'b1, 1'b1, 1'b0);
    check("lost_sync_locked", int'(locked), 0);
    check("lost_sync_valid", int'(pixel_valid), 0);
    check("lost_sync_err_count", int'(err_count), 3);

    // restore with mid-line vsync, then randomized line lengths and vsync placement
    for (int f = 0; f < 3; f++) send_frame(1, -1, -1, -1, 1'b0);
    check("midline_vsync_locked", int'(locked), 1);
    for (int f = 0; f < 4; f++) send_frame(int'($urandom_range(0, 1)), -1, -1, -1, 1'b1);

    // one-cycle reset mid-frame, then relock
    send_frame(0, -1, -1, 7, 1'b0);
    check("midreset_err_count", int'(err_count), 0);
    for (int f = 0; f < 3; f++) send_frame(0, -1, -1, -1, 1'b0);
    check("post_reset_locked", int'(locked), 1);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
    @(posedge vgaclk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Pixel-clock-domain receiver for the VGA raster our `vgaController` produces: it samples active-low hsync/vsync and 24-bit RGB, measures line timing, locks to the raster, and emits per-pixel (x, y, rgb) with a valid strobe for frame-buffer capture and self-check. It is the receiving end of the VGA link. It sits beside the controller in loopback, or behind a digitizer on an external source, and feeds a frame-buffer writer.

## Interface
- `HTOTAL`, 10'd801: expected clocks between consecutive hsync falling edges.
- `HOFFSET`, 10'd144: clocks from hsync assertion to first active pixel.
- `VOFFSET`, 10'd34: line index, after frame origin, of first active line.
- `WIDTH`, 10'd640: active pixels per line.
- `HEIGHT`, 10'd480: active lines per frame.
- `LOCK_LINES`, 4'd4: consecutive correct-length lines needed before lock.

- `vgaclk`  in  1  pixel clock; all logic on its rising edge.
- `reset_b`  in  1  reset; synchronous, active-low.
- `hsync`  in  1  horizontal sync, active low.
- `vsync`  in  1  vertical sync, active low.
- `r_in`, `g_in`, `b_in`  in  8 each  pixel colour.
- `x`, `y`  out  10 each  active-area coordinate of current output pixel.
- `rgb`  out  24  `{r,g,b}` of current output pixel.
- `pixel_valid`  out  1  x/y/rgb describe an active pixel.
- `frame_start`  out  1  one-cycle pulse at frame origin while locked.
- `locked`  out  1  high in LOCKED.
- `line_err`  out  1  one-cycle pulse on a bad line length while locked.
- `err_count`  out  8  saturating count of line errors since reset.

## Operation
- Inputs are registered once. Edge history resets to 1 (deasserted), so reset never produces a false edge.
- A fall is a registered sample of 0 after a 1.
- h counter: zero on hsync fall, +1 otherwise, saturates at 1023.
  - Measured line length = h + 1 at the fall.
- v counter and vsync handling:
  - A vsync fall sets `vpend`.
  - On an hsync fall, if `vpend` is set (including a vsync fall in the same cycle): v ← 0, `vpend` cleared, frame origin.
  - Otherwise v ← v + 1, saturating at 1023.
- FSM (reset state SEARCH):
  - SEARCH: on first hsync fall → ACQUIRE with good = 0.
  - ACQUIRE, on each hsync fall: length == HTOTAL → good +1 (saturating at 15); else good ← 0. If good ≥ LOCK_LINES at a frame-origin edge → LOCKED.
  - LOCKED, on each hsync fall: length ≠ HTOTAL → `line_err` pulse, `err_count` +1 (saturating at 255), miss +1; a second consecutive miss → SEARCH. A correct length clears miss.
  - LOCKED: h reaching 1023 (hsync lost) → SEARCH immediately, no `line_err`.
- `pixel_valid` = LOCKED ∧ HOFFSET ≤ h < HOFFSET+WIDTH ∧ VOFFSET ≤ v < VOFFSET+HEIGHT.
  - x = h − HOFFSET, y = v − VOFFSET, both 10-bit.
  - When not valid: x, y and rgb hold 0.
- `frame_start` pulses on a frame-origin edge taken in LOCKED, including the edge that enters LOCKED.
- `locked` tracks the state register.
- Leaving LOCKED drops `pixel_valid` on the next output cycle. `err_count` is kept.

## Timing
- Reset (`reset_b` low at an edge): state SEARCH; h, v, good, miss, `vpend`, `err_count` = 0. All outputs 0 after that edge. Reset mid-frame discards the lock.
- Latency is 2 cycles. A sample on the ports at edge k appears on x/y/rgb/`pixel_valid` after edge k+2. For that sample, h = k − k0, where k0 is the edge at which hsync was first sampled low.
- `frame_start`, `line_err` and `locked` transitions appear in the same output cycle as the pixel whose hsync fall caused them, i.e. 2 cycles after the port fall.
- No handshake: output is a free-running stream; the consumer must accept every `pixel_valid` cycle.
- One frame from our controller = 526 lines × 801 clocks. Lock is reached on the first frame origin after ≥ LOCK_LINES good lines, at most 1 frame + LOCK_LINES lines after reset.

## Test plan
- Reset: hold `reset_b` low 3 cycles with sync toggling → all outputs 0, no pulses, `locked` = 0.
- Lock on nominal `vgaController` stream:
  - `locked` rises with `frame_start` at the first frame origin after 4 good lines.
  - First `pixel_valid` has x = 0, y = 0, 146 cycles after the hsync fall of line v = 34.
  - Exactly 640 × 480 valid pixels per frame; next `frame_start` 526 × 801 cycles later.
- Pixel integrity: drive rgb = {h[7:0], v[7:0], 8'hA5} → each output satisfies rgb[23:16] = (x + 144)[7:0], rgb[15:8] = (y + 34)[7:0].
- Single bad line: one line of 800 clocks while locked → one `line_err` pulse, `err_count` = 1, `locked` stays 1. Two consecutive bad lines → `locked` falls 2 cycles after the second fall, `err_count` = 3 (cumulative over both tests).
- Lost sync: hold hsync high while locked → `locked` falls when h hits 1023, no `line_err`, `pixel_valid` 0 thereafter. Restoring hsync relocks per scenario 2.
- Coincident and reset cases:
  - vsync and hsync falling in the same cycle → that line is v = 0.
  - `reset_b` low for 1 cycle mid-frame → outputs 0 next cycle, relock on a later frame.
